mem_initiator: RTL
==================

# mem_initiator

Load/store initiator that sits between the pipeline's memory stage and the memory unit (RAM plus memory-mapped switch and output ports). It accepts one load or store request at a time through a valid/ready handshake and drives the memory unit's address, write-data, write-enable and read-enable lines. It returns a one-cycle response with extracted and extended load data. Byte and halfword stores are handled by read-modify-write, because the memory unit writes only full 32-bit words.

## Interface
- ADDR_WIDTH, 10, memory unit address width (byte address, word-aligned)
- READ_LATENCY, 1, clock edges from mem_read/mem_addr presented to mem_data_out valid (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high when the block can accept a request (state IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address; bits above ADDR_WIDTH-1 are ignored
- req_wdata  in  32  store data; sub-word data is taken from the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
- resp_err  out  1  with resp_valid: request rejected, no memory access made
- mem_addr  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2], 2'b00}, held for the whole access
- mem_wdata  out  32  to memory unit data_in
- mem_write_en  out  1  memory unit write_en
- mem_read  out  1  memory unit mem_read
- mem_rdata  in  32  memory unit data_out

## Operation
- States: IDLE, RD, RMW_RD, RMW_WR, WR, RESP.
- Registers captured on accept (req_valid & req_ready): addr, size, signed, write, wdata.
- Error check runs at accept. The request is rejected when any of these hold:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - sub-word store to the MMIO words. MMIO words are addr[ADDR_WIDTH-1:4] all ones with addr[3:2]≠00, which is 0x3F4/0x3F8/0x3FC for ADDR_WIDTH=10.
- A rejected request goes to RESP with resp_err=1 and makes no memory access.
- State transitions:
  - IDLE → WR: word store.
  - IDLE → RMW_RD: byte or half store.
  - IDLE → RD: load.
  - IDLE → RESP: error.
  - RD and RMW_RD: mem_read=1 for READ_LATENCY+1 cycles, tracked by a down-counter. mem_rdata is captured on the last cycle. Then RD → RESP and RMW_RD → RMW_WR.
  - RMW_WR: mem_write_en=1 for one cycle. mem_wdata is the captured word with the target lane replaced. Byte lane = addr[1:0]; half lane = addr[1] (0 → bits 15:0). Little-endian. Then → RESP.
  - WR: mem_write_en=1 for one cycle with mem_wdata=wdata, then → RESP.
  - RESP: resp_valid=1 for one cycle, then → IDLE. The consumer always accepts; there is no backpressure.
- Load extraction uses the same lane selection. Byte result = lane[7:0] extended; half result = lane[15:0] extended; word result is unmodified.
- mem_read and mem_write_en are never high together. Both are 0 outside RD/RMW_RD/WR/RMW_WR.

## Timing
- Reset (asynchronous):
  - State → IDLE; counter and captured registers → 0.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write_en=0, mem_addr=0, mem_wdata=0.
  - req_ready=1 once in IDLE.
- Accept edge = cycle 0. resp_valid timing, with L = READ_LATENCY:
  - error: cycle 1
  - word store: cycle 2
  - load: cycle L+2 (3 for L=1)
  - sub-word store: cycle L+3 (4 for L=1)
- req_ready is 0 from cycle 1 through RESP inclusive. Back-to-back requests are accepted the cycle after RESP.
- mem_addr is stable for every cycle that mem_read or mem_write_en is high. The MMIO port mux is address-decoded, so port reads also complete within the RD window.
- Reset mid-operation aborts the request. Strobes drop asynchronously, no resp_valid is issued, and a partially completed RMW performs no write.
- req_valid while not ready is ignored. The request must be held by the source.

## Test plan
- Word store 0xDEADBEEF to 0x010, then word load from 0x010 → resp_rdata=0xDEADBEEF, resp_err=0. Responses at cycles 2 and 3 after accept.
- Memory word 0x000000F0 at 0x020:
  - lb from 0x020 → 0xFFFFFFF0.
  - lbu from 0x020 → 0x000000F0.
  - lh from 0x022 → 0x00000000.
- Memory word 0x11223344 at 0x030; sb 0xAA to 0x031 → one write of 0x1122AA44 on mem_wdata in RMW_WR; resp_valid at cycle 4.
- Misaligned requests:
  - lh at 0x005 → resp_valid cycle 1, resp_err=1, resp_rdata=0, no mem_read/mem_write_en.
  - sb to 0x3FC → same error response.
- Switch port latched 0x0000005A; word load from 0x3F4 → resp_rdata=0x0000005A. Word store 0x12345678 to 0x3FC → output_port=0x12345678.
- Assert rst during RMW_RD of an sh → mem_read falls immediately, no write and no resp_valid; the memory word is unchanged on reload.

Source files
------------

// File: rtl/mem_initiator.sv
// Load/store initiator between the memory stage and the memory unit; sub-word stores by read-modify-write.
// Latency from accept: error 1, word store 2, load READ_LATENCY+2, sub-word store READ_LATENCY+3 cycles.
// One request in flight; req_ready only in IDLE, response is a one-cycle pulse with no backpressure.
module mem_initiator #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_write_en,
  output logic                  mem_read,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_RMW_WR = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  mmio_hit;
  logic                  req_err;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           load_data;
  logic [31:0]           merged;

  // Address bits above the memory unit's range are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  assign accept = req_valid && (state == S_IDLE);

  // Reject illegal size, misalignment, and sub-word stores to the MMIO words
  // (the ports have no lane enables, so an RMW there would be meaningless).
  always_comb begin
    mmio_hit = (&req_addr[ADDR_WIDTH-1:4]) && (req_addr[3:2] != 2'b00);
    req_err  = 1'b0;
    if (req_size == 2'b11)                              req_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0])             req_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (req_write && (req_size != 2'b10) && mmio_hit)   req_err = 1'b1;
  end

  // Sequencer: capture on accept, hold mem_read for READ_LATENCY+1 cycles, then write/respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr[ADDR_WIDTH-1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            cnt      <= CW'(READ_LATENCY);
            if (req_err)                 state <= S_RESP;
            else if (!req_write)         state <= S_RD;
            else if (req_size == 2'b10)  state <= S_WR;
            else                         state <= S_RMW_RD;
          end
        end
        S_RD, S_RMW_RD: begin
          if (cnt == '0) begin
            rdata_q <= mem_rdata;
            state   <= (state == S_RD) ? S_RESP : S_RMW_WR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RMW_WR, S_WR: state <= S_RESP;
        S_RESP:         state <= S_IDLE;
        default:        state <= S_IDLE;
      endcase
    end
  end

  // Lane selection (little-endian) and load extension from the captured word.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_lane = rdata_q[7:0];
      2'd1:    byte_lane = rdata_q[15:8];
      2'd2:    byte_lane = rdata_q[23:16];
      default: byte_lane = rdata_q[31:24];
    endcase
    half_lane = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_data = rdata_q;
    endcase
  end

  // Replace the target lane of the captured word with the store data.
  always_comb begin
    merged = rdata_q;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Strobes decode straight from state so a reset drops them immediately.
  always_comb begin
    req_ready    = (state == S_IDLE);
    mem_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    mem_read     = (state == S_RD) || (state == S_RMW_RD);
    mem_write_en = (state == S_WR) || (state == S_RMW_WR);
    mem_wdata    = '0;
    if (state == S_WR)     mem_wdata = wdata_q;
    if (state == S_RMW_WR) mem_wdata = merged;
    resp_valid   = (state == S_RESP);
    resp_err     = (state == S_RESP) && err_q;
    resp_rdata   = ((state == S_RESP) && !err_q && !write_q) ? load_data : 32'h0;
  end

endmodule
